// File: rtl/deserializer.sv
// Serial-to-parallel receiver: reassembles MSB-first frames into words and queues them in a 2-deep buffer.
// Optional trailing even-parity bit per frame when DESER_PARITY_EN is defined.
module deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             in_en,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             frame_err,
   output logic             overrun
`ifdef DESER_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT
`ifdef DESER_PARITY_EN
      ,
      PARITY
`endif
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic [WIDTH-1:0] word_nx;
   logic [WIDTH-1:0] push_word;
   logic             push;
   logic             ferr_nx;
`ifdef DESER_PARITY_EN
   logic             perr_nx;
`endif

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr, rd_ptr;
   logic [1:0]       count;
   logic             full, pop, accept;

   assign word_nx = {shreg[WIDTH-2:0], in};

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      shreg_nx  = shreg;
      push_word = word_nx;
      push      = 1'b0;
      ferr_nx   = 1'b0;
`ifdef DESER_PARITY_EN
      perr_nx   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (in_en) begin
               shreg_nx = {{(WIDTH-1){1'b0}}, in};
               cnt_nx   = CW'(1);
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (in_en) begin
               shreg_nx = word_nx;
               if (cnt == CW'(WIDTH - 1)) begin
                  cnt_nx = '0;
`ifdef DESER_PARITY_EN
                  state_nx = PARITY;
`else
                  // Returning to IDLE here lets the very next enabled bit start a new frame.
                  push     = 1'b1;
                  state_nx = IDLE;
`endif
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end else begin
               ferr_nx  = 1'b1;
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end
`ifdef DESER_PARITY_EN
         PARITY: begin
            push_word = shreg;
            state_nx  = IDLE;
            if (in_en) begin
               if (in == ^shreg) push = 1'b1;
               else              perr_nx = 1'b1;
            end else begin
               ferr_nx = 1'b1;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // A full buffer still accepts a push when the head is popped on the same edge.
   assign full       = (count == 2'd2);
   assign data_valid = (count != 2'd0);
   assign pop        = data_valid && data_ready;
   assign accept     = push && (!full || pop);
   assign data_out   = data_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         frame_err <= ferr_nx;
         overrun   <= push && full && !pop;
`ifdef DESER_PARITY_EN
         parity_err <= perr_nx;
`endif
         if (accept) wr_ptr <= ~wr_ptr;
         if (pop)    rd_ptr <= ~rd_ptr;
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Datapath storage carries no reset; data_out is masked while the buffer is empty.
   always_ff @(posedge clk) begin
      shreg <= shreg_nx;
      if (accept) mem[wr_ptr] <= push_word;
   end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer (WIDTH=8); parity cases build only with DESER_PARITY_EN.
module tb_deserializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n, in, in_en, data_ready;
   logic [WIDTH-1:0] data_out;
   logic             data_valid, frame_err, overrun;
`ifdef DESER_PARITY_EN
   logic             parity_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;
   int n_perr   = 0;
   logic [WIDTH-1:0] exp_q [$];

   always #5 clk = ~clk;

   deserializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in),
      .in_en      (in_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
`ifdef DESER_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Sample on the falling edge; stimulus changes 1ns after the rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) n_ferr++;
         if (overrun)   n_ovr++;
`ifdef DESER_PARITY_EN
         if (parity_err) n_perr++;
`endif
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0) check("unexpected_pop", exp_q.size(), 1);
            else                   check("pop_data", data_out, exp_q.pop_front());
         end
      end
   end

   task automatic drive(input logic b);
      @(posedge clk); #1;
      in_en = 1'b1;
      in    = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_en = 1'b0;
         in    = 1'b0;
      end
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input bit exp_push);
      for (int i = WIDTH - 1; i >= 0; i--) drive(w[i]);
`ifdef DESER_PARITY_EN
      drive(^w);
`endif
      if (exp_push) exp_q.push_back(w);
   endtask

   task automatic drain();
      @(posedge clk); #1;
      data_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; in = 1'b0; in_en = 1'b0; data_ready = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      check("rst_data_out", data_out, 0);
      check("rst_valid", data_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
`ifdef DESER_PARITY_EN
      check("rst_parity_err", parity_err, 0);
`endif
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      // Single frame, consumer always ready: one-cycle valid right after the last sample
      data_ready = 1'b1;
      send_word(8'h6E, 1'b1);
      @(posedge clk); #1 in_en = 1'b0;
      @(negedge clk);
      check("t1_valid_rise", data_valid, 1);
      check("t1_data", data_out, 8'h6E);
      @(negedge clk);
      check("t1_valid_fall", data_valid, 0);
      idle(2);

      // Back-to-back frames held in the buffer
      data_ready = 1'b0;
      send_word(8'h6E, 1'b1);
      send_word(8'h9B, 1'b1);
      idle(3);
      check("t2_valid", data_valid, 1);
      check("t2_head", data_out, 8'h6E);
      check("t2_no_ferr", n_ferr, 0);
      check("t2_no_ovr", n_ovr, 0);
      drain();

      // Overrun: third word dropped, first two kept
      @(posedge clk); #1 data_ready = 1'b0;
      send_word(8'h01, 1'b1);
      send_word(8'h02, 1'b1);
      send_word(8'h03, 1'b0);
      idle(3);
      check("t3_overrun_pulses", n_ovr, 1);
      check("t3_head", data_out, 8'h01);
      drain();

      // Aborted frame after 5 bits, then a clean frame
      drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b1); drive(1'b0);
      idle(3);
      check("t4_frame_err_pulses", n_ferr, 1);
      check("t4_no_push", data_valid, 0);
      send_word(8'hA5, 1'b1);
      idle(2);
      drain();

      // Reset mid-frame with a word pending in the buffer
      @(posedge clk); #1 data_ready = 1'b0;
      send_word(8'h55, 1'b0);
      drive(1'b0); drive(1'b0); drive(1'b1);
      @(posedge clk); #1;
      check("t5_pending_before_rst", data_valid, 1);
      rst_n = 1'b0; in_en = 1'b0;
      #1;
      check("t5_rst_valid", data_valid, 0);
      check("t5_rst_data", data_out, 0);
      check("t5_rst_ferr", frame_err, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);
      check("t5_no_ferr", n_ferr, 1);
      data_ready = 1'b1;
      send_word(8'h3C, 1'b1);
      idle(2);
      drain();

`ifdef DESER_PARITY_EN
      // Good parity accepted, bad parity rejected
      send_word(8'h6E, 1'b1);
      idle(2);
      drain();
      for (int i = WIDTH - 1; i >= 0; i--) drive(1'(8'h6E >> i));
      drive(1'b0);
      idle(3);
      check("t6_parity_err_pulses", n_perr, 1);
      check("t6_no_push", data_valid, 0);
`endif

      idle(3);
      check("end_queue_empty", exp_q.size(), 0);
      check("end_overrun_total", n_ovr, 1);
      check("end_frame_err_total", n_ferr, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
